dmem_responder: RTL and testbench

Shared data-memory responder for the threadbrain core array: the far end of the select stage's memory-request chain. It accepts at most one read request per cycle from the NCORES select stages and returns the data with a fixed two-cycle latency, which is exactly what the select stage's `mem_en → mem_en1 → mem_en2` pipeline consumes. It also absorbs register write-backs through a small write buffer, forwarding buffered data to reads so select always sees the newest cell value.

---
 rtl/threadbrain_pkg.sv | 37 +++
 rtl/dmem_wbuf.sv | 113 +++++++++++
 rtl/dmem_responder.sv | 149 ++++++++++++++
 tb/tb_dmem_responder.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/threadbrain_pkg.sv
// ============================================================================
//  Module      : threadbrain_pkg
//  Description : Shared types and constants for the threadbrain core array.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package threadbrain_pkg;

    typedef enum logic [1:0] {
        PLUS  = 2'd0,
        MINUS = 2'd1,
        BRZ   = 2'd2,
        PRINT = 2'd3
    } opcode_e;

    localparam int RF_VALID_W  = 1;
    localparam int RF_RETR_W   = 1;
    localparam int RF_LOCKED_W = 1;
    localparam int RF_TAG_W    = 16;
    localparam int RF_VAL_W    = 16;
    localparam int RF_ENTRY_W  = RF_VALID_W + RF_RETR_W + RF_LOCKED_W + RF_TAG_W + RF_VAL_W;

    typedef struct packed {
        logic [RF_VALID_W-1:0]  valid;
        logic [RF_RETR_W-1:0]   retr;
        logic [RF_LOCKED_W-1:0] locked;
        logic [RF_TAG_W-1:0]    tag;
        logic [RF_VAL_W-1:0]    val;
    } rf_entry_t;

    // Cycles from a memory request to its response, shared by select and responder.
    localparam int MEM_LAT = 2;

endpackage

`default_nettype wire

// File: rtl/dmem_wbuf.sv
// ============================================================================
//  Module      : dmem_wbuf
//  Description : Write buffer FIFO with CAM lookup, in-place merge and
//                read forwarding (entry 0 is always the head).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_wbuf
    import threadbrain_pkg::*;
#(
    parameter int IW   = 12,
    parameter int DW   = 16,
    parameter int WBUF = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [IW-1:0]         lk_addr,
    input  logic                  wr_acc,
    input  logic [IW-1:0]         wr_addr,
    input  logic [DW-1:0]         wr_data,
    input  logic                  pop,
    output logic                  hit,
    output logic [DW-1:0]         fwd_data,
    output logic [IW-1:0]         head_addr,
    output logic [DW-1:0]         head_data,
    output logic [$clog2(WBUF):0] count
);

    localparam int CW = $clog2(WBUF) + 1;

    logic [IW-1:0]   r_addr   [WBUF];
    logic [DW-1:0]   r_data   [WBUF];
    logic [CW-1:0]   r_count;
    logic [IW-1:0]   w_addr_n [WBUF];
    logic [DW-1:0]   w_data_n [WBUF];
    logic [CW-1:0]   w_count_n;
    logic [CW-1:0]   w_tail;
    logic [WBUF-1:0] w_wr_match;
    logic [WBUF-1:0] w_lk_match;
    logic [WBUF-1:0] w_merge_sel;
    logic            w_merge;
    logic            w_lk_same;

    always_comb begin
        for (int i = 0; i < WBUF; i++) begin
            w_wr_match[i] = (CW'(i) < r_count) && (r_addr[i] == wr_addr);
            w_lk_match[i] = (CW'(i) < r_count) && (r_addr[i] == lk_addr);
        end
    end

    assign w_merge   = wr_acc && (|w_wr_match);
    assign w_lk_same = wr_acc && (wr_addr == lk_addr);
    assign hit       = w_lk_same || (|w_lk_match);

    // Buffered addresses are unique, so at most one entry matches; the
    // same-cycle write is newer than anything buffered.
    always_comb begin
        fwd_data = '0;
        for (int i = 0; i < WBUF; i++) begin
            if (w_lk_match[i]) fwd_data = r_data[i];
        end
        if (w_lk_same) fwd_data = wr_data;
    end

    assign head_addr = r_addr[0];
    assign head_data = (wr_acc && w_wr_match[0]) ? wr_data : r_data[0];
    assign count     = r_count;

    // After a pop every entry moves down one slot, so merge and append
    // targets shift with it.
    assign w_merge_sel = pop ? (w_wr_match >> 1) : w_wr_match;
    assign w_tail      = r_count - {{(CW-1){1'b0}}, pop};

    always_comb begin
        w_addr_n = r_addr;
        w_data_n = r_data;
        if (pop) begin
            for (int i = 0; i < WBUF - 1; i++) begin
                w_addr_n[i] = r_addr[i+1];
                w_data_n[i] = r_data[i+1];
            end
        end
        for (int i = 0; i < WBUF; i++) begin
            if (w_merge && w_merge_sel[i]) begin
                w_data_n[i] = wr_data;
            end else if (wr_acc && !w_merge && (CW'(i) == w_tail)) begin
                w_addr_n[i] = wr_addr;
                w_data_n[i] = wr_data;
            end
        end
        w_count_n = w_tail + {{(CW-1){1'b0}}, (wr_acc && !w_merge)};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
            for (int i = 0; i < WBUF; i++) begin
                r_addr[i] <= '0;
                r_data[i] <= '0;
            end
        end else begin
            r_count <= w_count_n;
            for (int i = 0; i < WBUF; i++) begin
                r_addr[i] <= w_addr_n[i];
                r_data[i] <= w_data_n[i];
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/dmem_responder.sv
// ============================================================================
//  Module      : dmem_responder
//  Description : Shared data-memory responder: two-cycle read pipeline with a
//                forwarding write buffer. Optional DMEM_ERR_EN adds a sticky
//                protocol-error flag.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_responder
    import threadbrain_pkg::*;
#(
    parameter int NCORES = 4,
    parameter int AW     = 16,
    parameter int DW     = 16,
    parameter int DEPTH  = 4096,
    parameter int WBUF   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NCORES-1:0]    rd_en,
    input  logic [NCORES*AW-1:0] rd_addr,
    output logic [DW-1:0]        rd_data,
    output logic                 rd_valid,
    input  logic                 wr_en,
    input  logic [AW-1:0]        wr_addr,
    input  logic [DW-1:0]        wr_data,
    output logic                 wr_ready,
    output logic                 err
);

    localparam int               c_IW   = $clog2(DEPTH);
    localparam int               c_CW   = $clog2(WBUF) + 1;
    localparam logic [c_CW-1:0]  c_FULL = c_CW'(WBUF);

    logic            w_rd_req;
    logic [c_IW-1:0] w_sel_addr;
    logic            w_wr_acc;
    logic            w_drain;
    logic            w_hit;
    logic [DW-1:0]   w_fwd;
    logic [c_IW-1:0] w_head_addr;
    logic [DW-1:0]   w_head_data;
    logic [c_CW-1:0] w_count;

    logic            r_s1_valid;
    logic            r_s1_hit;
    logic [c_IW-1:0] r_s1_addr;
    logic [DW-1:0]   r_s1_fwd;
    logic [DW-1:0]   r_rd_data;
    logic            r_rd_valid;
    logic [DW-1:0]   r_mem [DEPTH];

    assign w_rd_req = |rd_en;

    // Descending scan so the lowest requesting core's address wins.
    always_comb begin
        w_sel_addr = '0;
        for (int i = NCORES - 1; i >= 0; i--) begin
            if (rd_en[i]) w_sel_addr = rd_addr[i*AW +: c_IW];
        end
    end

    generate
        if (AW > c_IW) begin : g_addr_hi
            logic w_unused_hi;
            always_comb begin
                w_unused_hi = ^wr_addr[AW-1:c_IW];
                for (int i = 0; i < NCORES; i++) begin
                    w_unused_hi = w_unused_hi ^ (^rd_addr[i*AW+c_IW +: AW-c_IW]);
                end
            end
        end
    endgenerate

    // The array port belongs to S2 whenever a read sits in S1.
    assign w_drain  = !r_s1_valid && (w_count != '0);
    assign wr_ready = (w_count < c_FULL) || w_drain;
    assign w_wr_acc = wr_en && wr_ready;

    dmem_wbuf #(
        .IW   (c_IW),
        .DW   (DW),
        .WBUF (WBUF)
    ) u_wbuf (
        .clk       (clk),
        .rst       (rst),
        .lk_addr   (w_sel_addr),
        .wr_acc    (w_wr_acc),
        .wr_addr   (wr_addr[c_IW-1:0]),
        .wr_data   (wr_data),
        .pop       (w_drain),
        .hit       (w_hit),
        .fwd_data  (w_fwd),
        .head_addr (w_head_addr),
        .head_data (w_head_data),
        .count     (w_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_hit   <= 1'b0;
            r_s1_addr  <= '0;
            r_s1_fwd   <= '0;
        end else begin
            r_s1_valid <= w_rd_req;
            r_s1_hit   <= w_hit;
            r_s1_addr  <= w_sel_addr;
            r_s1_fwd   <= w_fwd;
        end
    end

    always_ff @(posedge clk) begin
        if (w_drain) r_mem[w_head_addr] <= w_head_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            r_rd_valid <= r_s1_valid;
            if (r_s1_valid) r_rd_data <= r_s1_hit ? r_s1_fwd : r_mem[r_s1_addr];
        end
    end

    assign rd_valid = r_rd_valid;
    assign rd_data  = r_rd_data;

`ifdef DMEM_ERR_EN
    logic r_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (((rd_en & (rd_en - NCORES'(1))) != '0) || (wr_en && !wr_ready)) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;
`else
    assign err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_dmem_responder.sv
// ============================================================================
//  Module      : tb_dmem_responder
//  Description : Self-checking bench for dmem_responder against a
//                value-level memory model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dmem_responder;
    import threadbrain_pkg::*;

    localparam int NCORES = 4;
    localparam int AW     = 16;
    localparam int DW     = 16;
    localparam int DEPTH  = 4096;
    localparam int WBUF   = 4;
    localparam int IW     = 12;
`ifdef DMEM_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic                 clk;
    logic                 rst;
    logic [NCORES-1:0]    rd_en;
    logic [NCORES*AW-1:0] rd_addr;
    logic [DW-1:0]        rd_data;
    logic                 rd_valid;
    logic                 wr_en;
    logic [AW-1:0]        wr_addr;
    logic [DW-1:0]        wr_data;
    logic                 wr_ready;
    logic                 err;

    dmem_responder #(
        .NCORES (NCORES),
        .AW     (AW),
        .DW     (DW),
        .DEPTH  (DEPTH),
        .WBUF   (WBUF)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_ready (wr_ready),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit            v;
        logic [DW-1:0] d;
    } resp_t;

    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] arch [DEPTH];   // newest value of every cell
    logic [DW-1:0] arr  [DEPTH];   // what has actually reached the array
    int            pend [$];       // cells still waiting in the write buffer
    resp_t         pipe [$];
    bit            prev_rd;
    bit            exp_err;
    logic [DW-1:0] last_d;
    logic [11:0]   pool [8] = '{12'h010, 12'h020, 12'h030, 12'h040,
                                12'hABC, 12'hFFF, 12'h000, 12'h123};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [AW-1:0] paddr(input int k);
        logic [11:0] lo;
        lo = pool[k];
        return {4'($urandom), lo};
    endfunction

    task automatic model_reset();
        pend.delete();
        pipe.delete();
        for (int i = 0; i < MEM_LAT; i++) pipe.push_back('{v: 1'b0, d: '0});
        for (int i = 0; i < DEPTH; i++) arch[i] = arr[i];
        prev_rd = 1'b0;
        exp_err = 1'b0;
        last_d  = '0;
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic step(input logic [NCORES-1:0] ren, input logic [AW-1:0] raddr,
                        input logic wen, input logic [AW-1:0] waddr, input logic [DW-1:0] wdata);
        logic [NCORES*AW-1:0] bus;
        int                   low;
        int                   wi;
        int                   ri;
        int                   h;
        bit                   drain;
        bit                   ready;
        bit                   found;
        resp_t                cur;
        resp_t                nxt;
        for (int i = 0; i < NCORES; i++) bus[i*AW +: AW] = AW'($urandom);
        low = -1;
        for (int i = NCORES - 1; i >= 0; i--) if (ren[i]) low = i;
        if (low >= 0) bus[low*AW +: AW] = raddr;
        rd_en   = ren;
        rd_addr = bus;
        wr_en   = wen;
        wr_addr = waddr;
        wr_data = wdata;
        #1;
        cur = pipe.pop_front();
        chk("rd_valid", 32'(rd_valid), 32'(cur.v));
        if (cur.v) last_d = cur.d;
        chk("rd_data", 32'(rd_data), 32'(last_d));
        drain = !prev_rd && (pend.size() > 0);
        ready = (pend.size() < WBUF) || drain;
        chk("wr_ready", 32'(wr_ready), 32'(ready));
        chk("err", 32'(err), 32'(exp_err));
        if (ERR_EN && (($countones(ren) > 1) || (wen && !ready))) exp_err = 1'b1;
        if (wen && ready) begin
            wi = int'(waddr[IW-1:0]);
            arch[wi] = wdata;
            found = 1'b0;
            foreach (pend[k]) if (pend[k] == wi) found = 1'b1;
            if (!found) pend.push_back(wi);
        end
        if (drain) begin
            h = pend.pop_front();
            arr[h] = arch[h];
        end
        nxt.v = (low >= 0);
        nxt.d = '0;
        if (low >= 0) begin
            ri = int'(bus[low*AW +: IW]);
            nxt.d = arch[ri];
        end
        pipe.push_back(nxt);
        prev_rd = (low >= 0);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step('0, '0, 1'b0, '0, '0);
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        rd_en = '0;
        wr_en = 1'b0;
        #1;
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_rd_data", 32'(rd_data), 32'd0);
        chk("rst_wr_ready", 32'(wr_ready), 32'd1);
        chk("rst_err", 32'(err), 32'd0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst     = 1'b1;
        rd_en   = '0;
        rd_addr = '0;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        @(negedge clk);
        do_reset();

        // Preload every cell the bench reads; no reads, so each cycle drains.
        for (int k = 0; k < 8; k++) step('0, '0, 1'b1, paddr(k), 16'h1000 + 16'(k));
        step('0, '0, 1'b1, 16'h0010, 16'h00AB);
        idle(3);

        // Latency: core 2 reads 0x10, response only in T+2.
        step(4'b0100, 16'h0010, 1'b0, '0, '0);
        idle(3);

        // Same-cycle write forwarded to a read.
        step(4'b0001, 16'h0020, 1'b1, 16'h0020, 16'h0055);
        idle(3);

        // Fill the buffer under continuous reads, then a rejected merge.
        step(4'b0010, 16'h0030, 1'b0, '0, '0);
        for (int k = 0; k < 4; k++)
            step(4'b0001 << (k % 4), paddr(k + 3), 1'b1, paddr(k + 3), 16'(k + 1));
        step(4'b1000, paddr(3), 1'b1, paddr(3), 16'h0005);
        idle(4);

        // Read before and in the cycle of a write to the same cell.
        step(4'b0001, 16'h0030, 1'b0, '0, '0);
        step(4'b0010, 16'h0030, 1'b1, 16'h0030, 16'h0099);
        idle(3);

        // Reset with buffered writes and a read in flight.
        step(4'b0001, paddr(0), 1'b0, '0, '0);
        for (int k = 1; k < 4; k++)
            step(4'b0100, paddr(k), 1'b1, paddr(k), 16'hBEE0 + 16'(k));
        do_reset();
        for (int k = 1; k < 4; k++) begin
            step(4'b0001, paddr(k), 1'b0, '0, '0);
            idle(1);
        end
        idle(2);

        // Random traffic with one-hot reads.
        for (int n = 0; n < 400; n++) begin
            logic [NCORES-1:0] ren;
            ren = ($urandom_range(1) == 1) ? (NCORES'(1) << $urandom_range(NCORES - 1)) : '0;
            step(ren, paddr($urandom_range(7)), 1'($urandom_range(1)),
                 paddr($urandom_range(7)), DW'($urandom));
        end
        idle(3);

        // Two cores at once: lowest core's address is used.
        step(4'b0011, paddr(5), 1'b0, '0, '0);
        idle(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
